vz_image_loader: RTL and testbench

//  Sits between the HPS ioctl download stream and the LASER310 system RAM write port. Parses a .VZ image
//  (24-byte header + payload), streams the payload into RAM at the header load address, and holds the CPU
//  off RAM while loading. On completion it patches the BASIC pointers (type F0) or requests a jump (type F1).

---
 rtl/vz_image_loader.sv | 219 +++++++++++++++++++++
 tb/tb_vz_image_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vz_image_loader.sv
// vz_image_loader: parses a .VZ image arriving on the ioctl download stream,
// writes the payload into system RAM at the header load address, then either
// patches the BASIC start/end pointers (type F0) or requests a jump (type F1).
module vz_image_loader #(
    parameter logic [7:0]  IMAGE_INDEX = 8'd1,
    parameter logic [15:0] RAM_LO      = 16'h7800,
    parameter logic [15:0] PTR_START   = 16'h78A4,
    parameter logic [15:0] PTR_END     = 16'h78F9
) (
    input  logic        CLK10MHZ,
    input  logic        RESET,
    input  logic        dn_download,
    input  logic [7:0]  dn_index,
    input  logic [15:0] dn_addr,
    input  logic [7:0]  dn_data,
    input  logic        dn_wr,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_wr,
    output logic        busy,
    output logic        exec_req,
    output logic [15:0] exec_addr,
    output logic [7:0]  vz_type,
    output logic [15:0] end_addr,
    output logic        err,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE, S_MAGIC, S_NAME, S_HDR, S_DATA, S_PTR, S_DONE, S_ERR
    } state_t;

    localparam logic [7:0] TYPE_BASIC = 8'hF0;
    localparam logic [7:0] TYPE_MCODE = 8'hF1;

    // Magic signature "VZF0", indexed by header byte position.
    function automatic logic [7:0] magic_byte(input logic [1:0] pos);
        case (pos)
            2'd0:    magic_byte = 8'h56;
            2'd1:    magic_byte = 8'h5A;
            2'd2:    magic_byte = 8'h46;
            default: magic_byte = 8'h30;
        endcase
    endfunction

    state_t      r_state;
    state_t      w_state_next;
    logic        r_dl_prev;
    logic [1:0]  r_ptr_idx;
    logic [16:0] r_wr_ptr;      // bit 16 set means the payload ran past FFFF

    logic        w_sel;
    logic        w_active;
    logic        w_idle_like;
    logic        w_start;
    logic        w_in_hdr;
    logic        w_in_data;
    logic        w_byte;
    logic        w_magic_bad;
    logic        w_hdr_last;
    logic [15:0] w_load;
    logic        w_pay;
    logic [16:0] w_pay_addr;
    logic        w_pay_wrap;
    logic        w_pay_low;
    logic        w_pay_ok;
    logic [16:0] w_ptr_next;
    logic [15:0] w_end;
    logic        w_fin;
    logic        w_to_err;

    // Input decode: which byte is being offered and what it means for the load.
    always_comb begin
        w_sel       = (dn_index == IMAGE_INDEX);
        w_active    = dn_download && w_sel;
        w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR);
        w_start     = w_idle_like && w_active && !r_dl_prev;
        w_in_hdr    = w_start || (r_state == S_MAGIC) || (r_state == S_NAME) || (r_state == S_HDR);
        w_in_data   = (r_state == S_DATA);
        // A strobe in the cycle dn_download falls is still taken, because the
        // state has not yet left the load states at that point.
        w_byte      = dn_wr && w_sel && (w_in_hdr || w_in_data);
        w_magic_bad = w_byte && w_in_hdr && (dn_addr < 16'd4) &&
                      (dn_data != magic_byte(dn_addr[1:0]));
        w_hdr_last  = w_byte && w_in_hdr && (dn_addr == 16'd23);
        w_load      = {dn_data, exec_addr[7:0]};
        w_pay       = w_byte && w_in_data && (dn_addr >= 16'd24);
        w_pay_addr  = {1'b0, exec_addr} + {1'b0, dn_addr - 16'd24};
        w_pay_wrap  = w_pay_addr[16];
        w_pay_low   = !w_pay_wrap && (w_pay_addr[15:0] < RAM_LO);
        w_pay_ok    = w_pay && !w_pay_wrap && !w_pay_low;
        if (w_pay)
            w_ptr_next = w_pay_wrap ? 17'h10000 : w_pay_addr + 17'd1;
        else if (w_hdr_last)
            w_ptr_next = {1'b0, w_load};
        else
            w_ptr_next = r_wr_ptr;
        w_end = w_ptr_next[16] ? 16'h0000 : w_ptr_next[15:0];
    end

    // Next-state logic; header bytes are decoded by dn_addr, not arrival order.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_state_next = r_state;
        w_fin        = 1'b0;
        w_to_err     = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: w_state_next = S_IDLE;
            S_DATA:                if (!w_active) w_fin = 1'b1;
            S_PTR:                 if (r_ptr_idx == 2'd3) w_state_next = S_DONE;
            default:               ;
        endcase
        if (w_in_hdr) begin
            w_state_next = w_start ? S_MAGIC : r_state;
            if (w_magic_bad) begin
                w_to_err = 1'b1;
            end else if (w_hdr_last) begin
                if (w_active) w_state_next = S_DATA;
                else          w_fin        = 1'b1;
            end else if (!w_active) begin
                w_to_err = 1'b1;
            end else if (w_byte) begin
                if (dn_addr >= 16'd21)
                    w_state_next = S_HDR;
                else if (dn_addr >= 16'd3 && w_state_next == S_MAGIC)
                    w_state_next = S_NAME;
            end
        end
        if (w_fin)    w_state_next = (vz_type == TYPE_BASIC) ? S_PTR : S_DONE;
        if (w_to_err) w_state_next = S_ERR;
    end

    // State register.
    always_ff @(posedge CLK10MHZ or negedge RESET) begin
        if (!RESET) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Datapath: header fields, RAM write port, pointer patching and status flags.
    always_ff @(posedge CLK10MHZ or negedge RESET) begin
        if (!RESET) begin
            // r_dl_prev resets high so a download already in progress when reset
            // is released is not mistaken for a fresh start.
            r_dl_prev <= 1'b1;
            r_ptr_idx <= 2'd0;
            r_wr_ptr  <= 17'd0;
            mem_addr  <= 16'h0000;
            mem_data  <= 8'h00;
            mem_wr    <= 1'b0;
            busy      <= 1'b0;
            exec_req  <= 1'b0;
            exec_addr <= 16'h0000;
            vz_type   <= 8'h00;
            end_addr  <= 16'h0000;
            err       <= 1'b0;
            done      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register here
            // sees the pre-edge values of the others regardless of order.
            r_dl_prev <= dn_download;
            mem_wr    <= 1'b0;
            exec_req  <= 1'b0;

            if (w_start) begin
                done      <= 1'b0;
                err       <= 1'b0;
                busy      <= 1'b1;
                r_ptr_idx <= 2'd0;
            end

            if (w_byte && w_in_hdr) begin
                if (dn_addr == 16'd21) vz_type        <= dn_data;
                if (dn_addr == 16'd22) exec_addr[7:0]  <= dn_data;
                if (dn_addr == 16'd23) exec_addr[15:8] <= dn_data;
            end

            if (w_pay || w_hdr_last) r_wr_ptr <= w_ptr_next;

            if (w_pay_ok) begin
                mem_wr   <= 1'b1;
                mem_addr <= w_pay_addr[15:0];
                mem_data <= dn_data;
            end
            if (w_pay && !w_pay_ok) err <= 1'b1;

            if (w_to_err) begin
                busy <= 1'b0;
                err  <= 1'b1;
            end

            if (w_fin) begin
                end_addr <= w_end;
                if (vz_type == TYPE_MCODE) exec_req <= 1'b1;
                if (vz_type != TYPE_BASIC) begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
            end

            if (r_state == S_PTR) begin
                mem_wr    <= 1'b1;
                r_ptr_idx <= r_ptr_idx + 2'd1;
                case (r_ptr_idx)
                    2'd0: begin mem_addr <= PTR_START;         mem_data <= exec_addr[7:0];  end
                    2'd1: begin mem_addr <= PTR_START + 16'd1; mem_data <= exec_addr[15:8]; end
                    2'd2: begin mem_addr <= PTR_END;           mem_data <= end_addr[7:0];   end
                    default: begin
                        mem_addr <= PTR_END + 16'd1;
                        mem_data <= end_addr[15:8];
                        done     <= 1'b1;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vz_image_loader.sv
// tb_vz_image_loader: directed .VZ downloads against a queue-based model of
// the expected RAM writes and final status.
module tb_vz_image_loader;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dn_download = 1'b0;
    logic [7:0]  dn_index = 8'd0;
    logic [15:0] dn_addr = 16'd0;
    logic [7:0]  dn_data = 8'd0;
    logic        dn_wr = 1'b0;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_wr;
    logic        busy;
    logic        exec_req;
    logic [15:0] exec_addr;
    logic [7:0]  vz_type;
    logic [15:0] end_addr;
    logic        err;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;
    int exec_cnt = 0;

    logic [7:0] img [0:63];
    int         img_len;
    logic [7:0] magic_ref [0:3] = '{8'h56, 8'h5A, 8'h46, 8'h30};

    wr_t        exp_q [$];
    logic       m_done, m_err;
    logic [15:0] m_end;
    int         m_exec;

    vz_image_loader dut (
        .CLK10MHZ   (clk),
        .RESET      (rst_n),
        .dn_download(dn_download),
        .dn_index   (dn_index),
        .dn_addr    (dn_addr),
        .dn_data    (dn_data),
        .dn_wr      (dn_wr),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_wr     (mem_wr),
        .busy       (busy),
        .exec_req   (exec_req),
        .exec_addr  (exec_addr),
        .vz_type    (vz_type),
        .end_addr   (end_addr),
        .err        (err),
        .done       (done)
    );

    always #50 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Build an image: magic "VZF" + m3, name bytes, type, load address, payload base+i.
    task automatic make_image(input logic [7:0] m3, input logic [7:0] typ,
                              input logic [15:0] load, input int npay, input logic [7:0] base);
        img[0] = 8'h56; img[1] = 8'h5A; img[2] = 8'h46; img[3] = m3;
        for (int i = 4; i <= 20; i++) img[i] = 8'h41 + 8'(i);
        img[21] = typ;
        img[22] = load[7:0];
        img[23] = load[15:8];
        for (int i = 0; i < npay; i++) img[24 + i] = base + 8'(i);
        img_len = 24 + npay;
    endtask

    // Expected RAM writes and final status for the current image.
    task automatic model_load();
        bit bad = 1'b0;
        int load, npay, a, e;
        m_done = 1'b0; m_err = 1'b0; m_end = 16'h0000; m_exec = 0;
        for (int i = 0; i < 4 && i < img_len; i++)
            if (img[i] != magic_ref[i]) bad = 1'b1;
        if (bad || img_len < 24) begin
            m_err = 1'b1;
            return;
        end
        load = {img[23], img[22]};
        npay = img_len - 24;
        for (int i = 0; i < npay; i++) begin
            a = load + i;
            if (a > 32'hFFFF || a < 32'h7800) m_err = 1'b1;
            else exp_q.push_back({a[15:0], img[24 + i]});
        end
        e = load + npay;
        m_end  = (e > 32'hFFFF) ? 16'h0000 : e[15:0];
        m_done = 1'b1;
        m_exec = (img[21] == 8'hF1) ? 1 : 0;
        if (img[21] == 8'hF0) begin
            exp_q.push_back({16'h78A4, img[22]});
            exp_q.push_back({16'h78A5, img[23]});
            exp_q.push_back({16'h78F9, m_end[7:0]});
            exp_q.push_back({16'h78FA, m_end[15:8]});
        end
    endtask

    task automatic send_byte(input int i);
        dn_addr = 16'(i); dn_data = img[i]; dn_wr = 1'b1;
        @(posedge clk); #1;
        dn_wr = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] idx, input int nbytes);
        @(posedge clk); #1;
        dn_index = idx; dn_download = 1'b1;
        repeat (2) @(posedge clk); #1;
        for (int i = 0; i < nbytes; i++) send_byte(i);
        dn_download = 1'b0;
        repeat (10) @(posedge clk); #1;
    endtask

    task automatic check_result(input int exec_before);
        check("done", done, m_done);
        check("err", err, m_err);
        check("busy_end", busy, 0);
        check("exec_pulses", exec_cnt - exec_before, m_exec);
        check("pending_wr", exp_q.size(), 0);
        if (m_done) begin
            check("end_addr", end_addr, m_end);
            check("vz_type", vz_type, img[21]);
            check("exec_addr", exec_addr, {img[23], img[22]});
        end
    endtask

    initial begin
        int eb;
        wr_t w;

        // Compare process: every RAM write must be the next one the model expects.
        fork
            forever begin
                @(negedge clk);
                if (mem_wr) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_wr_addr", mem_addr, 16'hxxxx);
                    end else begin
                        w = exp_q.pop_front();
                        check("wr_addr", mem_addr, w.addr);
                        check("wr_data", mem_data, w.data);
                    end
                end
                if (exec_req) exec_cnt++;
            end
        join_none

        #20;
        check("rst_outputs", {mem_addr, mem_data, mem_wr, busy, exec_req, exec_addr,
                              vz_type, end_addr, err, done}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // F0 image, load 7AE9, payload 11..15.
        make_image(8'h30, 8'hF0, 16'h7AE9, 5, 8'h11);
        model_load();
        check("model_f0_size", exp_q.size(), 9);
        check("model_f0_first", exp_q[0], {16'h7AE9, 8'h11});
        check("model_f0_end_lo", exp_q[7], {16'h78F9, 8'hEE});
        check("model_f0_end_hi", exp_q[8], {16'h78FA, 8'h7A});
        eb = exec_cnt;
        send(8'd1, img_len);
        check_result(eb);
        check("f0_end_literal", end_addr, 16'h7AEE);

        // F1 image, load 8000, 3 bytes.
        make_image(8'h30, 8'hF1, 16'h8000, 3, 8'hA0);
        model_load();
        eb = exec_cnt;
        send(8'd1, img_len);
        check_result(eb);
        check("f1_exec_literal", exec_addr, 16'h8000);
        check("f1_end_literal", end_addr, 16'h8003);

        // Bad magic "VZFX": rejected at byte 3.
        make_image(8'h58, 8'hF0, 16'h8000, 3, 8'h01);
        model_load();
        eb = exec_cnt;
        @(posedge clk); #1;
        dn_index = 8'd1; dn_download = 1'b1;
        repeat (2) @(posedge clk); #1;
        for (int i = 0; i < 4; i++) send_byte(i);
        check("magic_busy", busy, 0);
        check("magic_err", err, 1);
        for (int i = 4; i < img_len; i++) send_byte(i);
        dn_download = 1'b0;
        repeat (10) @(posedge clk); #1;
        check_result(eb);

        // Short image: download ends after 20 bytes.
        make_image(8'h30, 8'hF0, 16'h8000, 3, 8'h01);
        img_len = 20;
        model_load();
        eb = exec_cnt;
        send(8'd1, img_len);
        check_result(eb);

        // Address wrap: load FFFE, 4 bytes, plain type.
        make_image(8'h30, 8'h20, 16'hFFFE, 4, 8'hC0);
        model_load();
        check("model_wrap_end", m_end, 16'h0000);
        eb = exec_cnt;
        send(8'd1, img_len);
        check_result(eb);

        // Below RAM_LO: load 77FE, first two bytes dropped, pointers still patched.
        make_image(8'h30, 8'hF0, 16'h77FE, 4, 8'h50);
        model_load();
        eb = exec_cnt;
        send(8'd1, img_len);
        check_result(eb);

        // Reset during DATA after 10 payload bytes.
        make_image(8'h30, 8'hF0, 16'h8000, 20, 8'h40);
        for (int i = 0; i < 10; i++) exp_q.push_back({16'h8000 + 16'(i), 8'h40 + 8'(i)});
        @(posedge clk); #1;
        dn_index = 8'd1; dn_download = 1'b1;
        repeat (2) @(posedge clk); #1;
        for (int i = 0; i < 34; i++) send_byte(i);
        check("busy_mid_load", busy, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", {mem_addr, mem_data, mem_wr, busy, exec_req, exec_addr,
                                  vz_type, end_addr, err, done}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 34; i < img_len; i++) send_byte(i);
        dn_download = 1'b0;
        repeat (10) @(posedge clk); #1;
        check("rst_pending_wr", exp_q.size(), 0);
        check("rst_after_busy", busy, 0);
        check("rst_after_done", done, 0);

        // Wrong index: nothing happens.
        make_image(8'h30, 8'hF0, 16'h8000, 3, 8'h01);
        eb = exec_cnt;
        send(8'd0, img_len);
        check("idx0_flags", {busy, err, done, end_addr}, 0);
        check("idx0_exec", exec_cnt - eb, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
